// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the multicycle RV32I control path: FSM state type,
//   opcode constants, mux/ALU encodings and small decode helpers.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp: how the ALU decoder chooses the operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUctrl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALUsrcA / ALUsrcB
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BR:   imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

    // ALU-class instructions support add/sub, slt, or, and only.
    function automatic logic alu_f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
//   Combinational ALU operation select.
//   aluop_i    : 00 add, 01 sub, 10 decode from funct3/funct7b5
//   funct3_i   : IR[14:12]
//   funct7b5_i : IR[30]
//   op5_i      : opcode bit 5 (1 = R-type, 0 = I-type ALU op)
//   alu_ctrl_o : ALU operation
// ---------------------------------------------------------------------------
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // IR[30] only selects sub for register-register ops;
                    // for addi it is immediate data.
                    3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    3'b111:  alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multicycle RV32I control FSM (lw, sw, R-type, I-ALU, beq/bne, jal) for a
//   shared-memory datapath, with a memory ready handshake and a sticky
//   illegal-instruction flag.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   instr_opcode/funct3/funct7b5 : instruction fields from IR
//   EQ                  : ALU zero flag (rs1 == rs2)
//   mem_ready           : memory access completes this cycle
//   PCWrite/IRWrite/MemWrite/RegWrite : datapath enables
//   AdrSrc/ResultSrc/ALUsrcA/ALUsrcB/ALUctrl/ImmSrc : datapath mux/ALU selects
//   illegal_instr       : sticky, set on entry to ILLEGAL, cleared by reset
// ---------------------------------------------------------------------------
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W     = 3,
    parameter int unsigned IMMSRC_W      = 2,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          BNE_EN        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           instr_opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 EQ,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUsrcA,
    output logic [1:0]           ALUsrcB,
    output logic [ALUCTRL_W-1:0] ALUctrl,
    output logic [IMMSRC_W-1:0]  ImmSrc,
    output logic                 RegWrite,
    output logic                 illegal_instr
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       ready;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;
    logic       pc_write, ir_write, mem_write, reg_write;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    alu_decoder u_alu_decoder (
        .aluop_i    (alu_op),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .op5_i      (instr_opcode[5]),
        .alu_ctrl_o (alu_ctrl)
    );

    always_comb begin
        state_d   = state_q;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUsrcA   = SRCA_PC;
        ALUsrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUsrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUsrcA = SRCA_OLDPC;
                ALUsrcB = SRCB_IMM;
                case (instr_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = alu_f3_legal(funct3) ? S_EXECR : S_ILLEGAL;
                    OP_I:         state_d = alu_f3_legal(funct3) ? S_EXECI : S_ILLEGAL;
                    OP_BR:        state_d = ((funct3 == 3'b000) || (BNE_EN && (funct3 == 3'b001)))
                                            ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUsrcA = SRCA_RS1;
                ALUsrcB = SRCB_IMM;
                state_d = (instr_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEM;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUsrcA = SRCA_RS1;
                ALUsrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUsrcA = SRCA_RS1;
                ALUsrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA  = SRCA_RS1;
                ALUsrcB  = SRCB_RS2;
                alu_op   = ALUOP_SUB;
                // Only beq/bne reach this state.
                pc_write = (funct3 == 3'b001) ? ~EQ : EQ;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target from DECODE) while the ALU forms
                // oldPC + 4 for the link write in ALUWB.
                ALUsrcA  = SRCA_OLDPC;
                ALUsrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase

        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // FETCH is the reset state and would otherwise raise IRWrite/PCWrite
    // from mem_ready while reset is still held.
    assign PCWrite       = pc_write  & rst_n;
    assign IRWrite       = ir_write  & rst_n;
    assign MemWrite      = mem_write & rst_n;
    assign RegWrite      = reg_write & rst_n;
    assign ALUctrl       = ALUCTRL_W'(alu_ctrl);
    assign ImmSrc        = IMMSRC_W'(imm_src_of(instr_opcode));
    assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Each instruction is run with a
//   chosen fetch/memory stall pattern; per-cycle enables are collected as bit
//   masks over the instruction's cycles and compared with masks computed
//   from instruction latency arithmetic.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] instr_opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       EQ;
    logic       mem_ready;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUsrcA, ALUsrcB, ImmSrc;
    logic [2:0] ALUctrl;

    logic       nb_PCWrite, nb_AdrSrc, nb_MemWrite, nb_IRWrite, nb_RegWrite, nb_illegal;
    logic [1:0] nb_ResultSrc, nb_ALUsrcA, nb_ALUsrcB, nb_ImmSrc;
    logic [2:0] nb_ALUctrl;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    always #5 clk = ~clk;

    multicycle_control #(
        .ALUCTRL_W(3), .IMMSRC_W(2), .MEM_HANDSHAKE(1'b1), .BNE_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .funct3(funct3),
        .funct7b5(funct7b5), .EQ(EQ), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUctrl(ALUctrl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_instr(illegal_instr)
    );

    multicycle_control #(
        .ALUCTRL_W(3), .IMMSRC_W(2), .MEM_HANDSHAKE(1'b1), .BNE_EN(1'b0)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .funct3(funct3),
        .funct7b5(funct7b5), .EQ(EQ), .mem_ready(mem_ready),
        .PCWrite(nb_PCWrite), .AdrSrc(nb_AdrSrc), .MemWrite(nb_MemWrite), .IRWrite(nb_IRWrite),
        .ResultSrc(nb_ResultSrc), .ALUsrcA(nb_ALUsrcA), .ALUsrcB(nb_ALUsrcB), .ALUctrl(nb_ALUctrl),
        .ImmSrc(nb_ImmSrc), .RegWrite(nb_RegWrite), .illegal_instr(nb_illegal)
    );

    typedef struct {
        logic [31:0] irw, pcw, rw, mw, adr;
        logic [2:0]  alu_e;
        logic [1:0]  a_e, b_e, imm_d, res_last;
        int          overlap;
        logic        at_fetch;
    } trace_t;

    // ---------------- reference model ----------------
    function automatic bit is_mem(input logic [6:0] op);
        return (op == LW) || (op == SW);
    endfunction

    function automatic int n_cycles(input logic [6:0] op, input int s_f, input int s_m);
        int base;
        if (op == LW)      base = 5;
        else if (op == BR) base = 3;
        else               base = 4;
        return base + s_f + (is_mem(op) ? s_m : 0);
    endfunction

    function automatic logic [2:0] alu_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (op == BR) return 3'b001;
        if (op != RT && op != IT) return 3'b000;
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    // Cycle 0 is the first FETCH cycle. The fetch completes at cycle s_f, the
    // third instruction step (address/execute/branch/jal) lands at s_f+2, and
    // the memory access occupies s_m+1 cycles starting at s_f+3.
    function automatic trace_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic eq, input int s_f, input int s_m);
        trace_t t;
        int n, e;
        logic writes, taken;
        logic [31:0] memmask;
        n = n_cycles(op, s_f, s_m);
        e = s_f + 2;
        writes  = (op == LW) || (op == RT) || (op == IT) || (op == JAL);
        taken   = (op == JAL) || ((op == BR) && ((f3 == 3'b001) ? !eq : eq));
        memmask = ((32'd1 << (s_m + 1)) - 32'd1) << (s_f + 3);
        t.irw      = 32'd1 << s_f;
        t.pcw      = (32'd1 << s_f) | (taken ? (32'd1 << e) : 32'd0);
        t.rw       = writes ? (32'd1 << (n - 1)) : 32'd0;
        t.mw       = (op == SW) ? memmask : 32'd0;
        t.adr      = is_mem(op) ? memmask : 32'd0;
        t.alu_e    = alu_ref(op, f3, f7);
        t.a_e      = (op == JAL) ? 2'b01 : 2'b10;
        t.b_e      = (op == JAL) ? 2'b10 : ((op == RT || op == BR) ? 2'b00 : 2'b01);
        t.imm_d    = (op == SW) ? 2'b01 : (op == BR) ? 2'b10 : (op == JAL) ? 2'b11 : 2'b00;
        t.res_last = (op == LW) ? 2'b01 : 2'b00;
        t.overlap  = 0;
        t.at_fetch = 1'b1;
        return t;
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one instruction from its first FETCH cycle; assumes the DUT is
    // in FETCH and the time is just after a rising edge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic eq, input int s_f, input int s_m, output trace_t o);
        int n, m0;
        n  = n_cycles(op, s_f, s_m);
        m0 = s_f + 3;
        o  = '{default: '0};
        instr_opcode = op; funct3 = f3; funct7b5 = f7; EQ = eq;
        for (int c = 0; c < n; c++) begin
            if (c < s_f)                                      mem_ready = 1'b0;
            else if (c == s_f)                                mem_ready = 1'b1;
            else if (is_mem(op) && c >= m0 && c < m0 + s_m)   mem_ready = 1'b0;
            else if (is_mem(op) && c == m0 + s_m)             mem_ready = 1'b1;
            else                                              mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            o.irw[c] = IRWrite;
            o.pcw[c] = PCWrite;
            o.rw[c]  = RegWrite;
            o.mw[c]  = MemWrite;
            o.adr[c] = AdrSrc;
            if (int'(MemWrite) + int'(RegWrite) + int'(IRWrite) > 1) o.overlap++;
            if (c == s_f + 1) o.imm_d = ImmSrc;
            if (c == s_f + 2) begin
                o.alu_e = ALUctrl; o.a_e = ALUsrcA; o.b_e = ALUsrcB;
            end
            if (c == n - 1) o.res_last = ResultSrc;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1;
        o.at_fetch = (ALUsrcA == 2'b00) && (ALUsrcB == 2'b10) && (ResultSrc == 2'b10) &&
                     !IRWrite && !RegWrite && !MemWrite && !PCWrite;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; EQ = 1'b1;
        instr_opcode = SW; funct3 = 3'b010; funct7b5 = 1'b0;
        @(negedge clk);
        total++; if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin bad++;
            $display("FAIL reset_enables: got %b want 0000", {PCWrite, MemWrite, IRWrite, RegWrite}); end
        total++; if (illegal_instr !== 1'b0) begin bad++;
            $display("FAIL reset_illegal: got %b want 0", illegal_instr); end
        total++; if ({AdrSrc, ALUsrcA, ALUsrcB, ResultSrc} !== 7'b0_00_10_10) begin bad++;
            $display("FAIL reset_muxes: got %b want 0001010", {AdrSrc, ALUsrcA, ALUsrcB, ResultSrc}); end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if ({IRWrite, ALUsrcB, ResultSrc} !== 5'b0_10_10) begin bad++;
            $display("FAIL reset_release_fetch: got %b want 01010", {IRWrite, ALUsrcB, ResultSrc}); end
    endtask

    task automatic test_lw();
        trace_t o, e;
        // lw x1, 0(x0) = 0x0000_2083
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, o);
        e = model(LW, 3'b010, 1'b0, 1'b0, 0, 0);
        total++; if (o.rw !== e.rw) begin bad++;
            $display("FAIL lw_regwrite: got %h want %h", o.rw, e.rw); end
        total++; if (o.res_last !== 2'b01) begin bad++;
            $display("FAIL lw_resultsrc: got %b want 01", o.res_last); end
        total++; if (o.adr !== e.adr) begin bad++;
            $display("FAIL lw_adrsrc: got %h want %h", o.adr, e.adr); end
        total++; if (o.at_fetch !== 1'b1) begin bad++;
            $display("FAIL lw_latency: got fetch=%b want 1 after 5 cycles", o.at_fetch); end
    endtask

    task automatic test_sw_stall();
        trace_t o, e;
        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, o);
        e = model(SW, 3'b010, 1'b0, 1'b0, 0, 3);
        total++; if (o.mw !== e.mw) begin bad++;
            $display("FAIL sw_memwrite_hold: got %h want %h", o.mw, e.mw); end
        total++; if (o.rw !== 32'd0) begin bad++;
            $display("FAIL sw_regwrite: got %h want 0", o.rw); end
        total++; if (o.at_fetch !== 1'b1) begin bad++;
            $display("FAIL sw_return_fetch: got %b want 1", o.at_fetch); end
    endtask

    task automatic test_branch();
        trace_t o, e;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] f3;
            logic       eq;
            f3 = (k >= 2) ? 3'b001 : 3'b000;
            eq = 1'(k % 2);
            run_instr(BR, f3, 1'b0, eq, 0, 0, o);
            e = model(BR, f3, 1'b0, eq, 0, 0);
            total++; if (o.pcw !== e.pcw) begin bad++;
                $display("FAIL branch_pcwrite f3=%b eq=%b: got %h want %h", f3, eq, o.pcw, e.pcw); end
            total++; if (o.alu_e !== 3'b001) begin bad++;
                $display("FAIL branch_sub f3=%b: got %b want 001", f3, o.alu_e); end
            total++; if (o.at_fetch !== 1'b1) begin bad++;
                $display("FAIL branch_latency f3=%b eq=%b: got %b want 1", f3, eq, o.at_fetch); end
        end
    endtask

    task automatic test_alu();
        trace_t o;
        logic [6:0] ops  [5] = '{RT, RT, IT, IT, RT};
        logic [2:0] f3s  [5] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b111};
        logic       f7s  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] want [5] = '{3'b000, 3'b001, 3'b000, 3'b101, 3'b010};
        for (int k = 0; k < 5; k++) begin
            run_instr(ops[k], f3s[k], f7s[k], 1'b0, 0, 0, o);
            total++; if (o.alu_e !== want[k]) begin bad++;
                $display("FAIL alu_ctrl case%0d: got %b want %b", k, o.alu_e, want[k]); end
            total++; if (o.rw !== 32'h8) begin bad++;
                $display("FAIL alu_writeback case%0d: got %h want 00000008", k, o.rw); end
        end
    endtask

    task automatic test_bne_disabled();
        do_reset();
        instr_opcode = BR; funct3 = 3'b001; funct7b5 = 1'b0; EQ = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (nb_illegal !== 1'b1) begin bad++;
            $display("FAIL bne_disabled_illegal: got %b want 1", nb_illegal); end
        total++; if (nb_PCWrite !== 1'b0) begin bad++;
            $display("FAIL bne_disabled_pcwrite: got %b want 0", nb_PCWrite); end
        total++; if ({illegal_instr, PCWrite} !== 2'b01) begin bad++;
            $display("FAIL bne_enabled_taken: got %b want 01", {illegal_instr, PCWrite}); end
        do_reset();
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3] = '{7'h7F, RT, IT};
        logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b100};
        for (int k = 0; k < 3; k++) begin
            int en_cycles, clr_cycles;
            en_cycles = 0; clr_cycles = 0;
            instr_opcode = ops[k]; funct3 = f3s[k]; funct7b5 = 1'b0; EQ = 1'b0;
            mem_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            for (int c = 0; c < 20; c++) begin
                mem_ready    = 1'($urandom_range(0, 1));
                EQ           = 1'($urandom_range(0, 1));
                funct3       = 3'($urandom_range(0, 7));
                instr_opcode = (c % 2 == 0) ? 7'($urandom_range(0, 127)) : LW;
                @(negedge clk);
                if (PCWrite || IRWrite || MemWrite || RegWrite) en_cycles++;
                if (!illegal_instr) clr_cycles++;
                @(posedge clk); #1;
            end
            total++; if (en_cycles !== 0) begin bad++;
                $display("FAIL illegal_enables case%0d: got %0d enable cycles want 0", k, en_cycles); end
            total++; if (clr_cycles !== 0) begin bad++;
                $display("FAIL illegal_sticky case%0d: got %0d clear cycles want 0", k, clr_cycles); end
            rst_n = 1'b0;
            #1;
            total++; if (illegal_instr !== 1'b0) begin bad++;
                $display("FAIL illegal_cleared case%0d: got %b want 0", k, illegal_instr); end
            do_reset();
        end
    endtask

    task automatic test_reset_midwrite();
        do_reset();
        instr_opcode = SW; funct3 = 3'b010; funct7b5 = 1'b0; EQ = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (MemWrite !== 1'b1) begin bad++;
            $display("FAIL midwrite_active: got %b want 1", MemWrite); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (MemWrite !== 1'b0) begin bad++;
            $display("FAIL midwrite_reset_async: got %b want 0", MemWrite); end
        mem_ready = 1'b1;
        @(negedge clk);
        total++; if ({PCWrite, IRWrite} !== 2'b00) begin bad++;
            $display("FAIL midwrite_reset_gated: got %b want 00", {PCWrite, IRWrite}); end
        rst_n = 1'b1;
        #1;
        total++; if ({AdrSrc, ALUsrcA, ALUsrcB, ResultSrc, IRWrite, PCWrite} !== 9'b0_00_10_10_1_1) begin bad++;
            $display("FAIL midwrite_fetch_after: got %b want 000101011",
                     {AdrSrc, ALUsrcA, ALUsrcB, ResultSrc, IRWrite, PCWrite}); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        trace_t o, e;
        logic [2:0] alu_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f7, eq, writes;
            int         k, s_f, s_m;
            k   = $urandom_range(0, 5);
            f7  = 1'($urandom_range(0, 1));
            eq  = 1'($urandom_range(0, 1));
            s_f = $urandom_range(0, 2);
            s_m = $urandom_range(0, 2);
            case (k)
                0:       begin op = LW;  f3 = 3'b010; end
                1:       begin op = SW;  f3 = 3'b010; end
                2:       begin op = RT;  f3 = alu_f3[$urandom_range(0, 3)]; end
                3:       begin op = IT;  f3 = alu_f3[$urandom_range(0, 3)]; end
                4:       begin op = BR;  f3 = 3'($urandom_range(0, 1)); end
                default: begin op = JAL; f3 = 3'($urandom_range(0, 7)); end
            endcase
            writes = (op == LW) || (op == RT) || (op == IT) || (op == JAL);
            run_instr(op, f3, f7, eq, s_f, s_m, o);
            e = model(op, f3, f7, eq, s_f, s_m);
            total++; if (o.irw !== e.irw) begin bad++;
                $display("FAIL b2b[%0d] op=%b irwrite: got %h want %h", i, op, o.irw, e.irw); end
            total++; if (o.pcw !== e.pcw) begin bad++;
                $display("FAIL b2b[%0d] op=%b pcwrite: got %h want %h", i, op, o.pcw, e.pcw); end
            total++; if (o.rw !== e.rw) begin bad++;
                $display("FAIL b2b[%0d] op=%b regwrite: got %h want %h", i, op, o.rw, e.rw); end
            total++; if (o.mw !== e.mw) begin bad++;
                $display("FAIL b2b[%0d] op=%b memwrite: got %h want %h", i, op, o.mw, e.mw); end
            total++; if (o.adr !== e.adr) begin bad++;
                $display("FAIL b2b[%0d] op=%b adrsrc: got %h want %h", i, op, o.adr, e.adr); end
            total++; if ({o.alu_e, o.a_e, o.b_e} !== {e.alu_e, e.a_e, e.b_e}) begin bad++;
                $display("FAIL b2b[%0d] op=%b alu/srcA/srcB: got %b want %b", i, op,
                         {o.alu_e, o.a_e, o.b_e}, {e.alu_e, e.a_e, e.b_e}); end
            total++; if (o.imm_d !== e.imm_d) begin bad++;
                $display("FAIL b2b[%0d] op=%b immsrc: got %b want %b", i, op, o.imm_d, e.imm_d); end
            if (writes) begin
                total++; if (o.res_last !== e.res_last) begin bad++;
                    $display("FAIL b2b[%0d] op=%b resultsrc_wb: got %b want %b", i, op, o.res_last, e.res_last); end
            end
            total++; if (o.overlap !== 0) begin bad++;
                $display("FAIL b2b[%0d] op=%b write_overlap: got %0d want 0", i, op, o.overlap); end
            total++; if (o.at_fetch !== 1'b1) begin bad++;
                $display("FAIL b2b[%0d] op=%b latency_end: got %b want 1", i, op, o.at_fetch); end
        end
        total++; if (illegal_instr !== 1'b0) begin bad++;
            $display("FAIL b2b_no_illegal: got %b want 0", illegal_instr); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_alu();
        test_bne_disabled();
        test_illegal();
        test_reset_midwrite();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
